line_ram_responder: RTL
=======================

# line_ram_responder

Responder for the 64-bit cache-line memory port used by the cache/SDRAM-controller pair (`req`/`wren`/`address`/`page`/`ready`). It sits in place of the SDRAM controller's data port and serves line requests from `d_cache` out of on-chip block RAM. Uses for it are SDRAM-less builds and a deterministic memory behind the cache in simulation. Each 64-bit line is stored as four 16-bit words, matching the SDRAM data width, so every request costs a fixed four-beat transfer.

## Interface
Parameters:
- `ADDR_W`, 13: width of `mem_address` (line address within page).
- `PAGE_W`, 7: width of `mem_page`.
- `LINE_AW`, 10: local line-index width; RAM depth is 4·2^LINE_AW 16-bit words.

Ports:
- `clk`  in  1  system clock (`clk_sys` domain); single clock.
- `n_reset`  in  1  synchronous, active-low reset.
- `mem_address`  in  ADDR_W  line address from the requester.
- `mem_page`  in  PAGE_W  page select.
- `mem_req`  in  1  request; held high until `mem_ready` is seen.
- `mem_wren`  in  1  1 = write line, 0 = read line; qualified by `mem_req`.
- `to_mem`  in  64  write line data.
- `from_mem`  out  64  read line data.
- `mem_ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while a request is being serviced or awaiting release.

## Operation
- Line index: `{mem_page, mem_address}` truncated to its low LINE_AW bits. Upper bits are ignored, so lines alias modulo 2^LINE_AW.
- Word address: `{line_index, beat[1:0]}`.
- Beat k maps to line bits [16k+15:16k]; word 0 is the least significant word.
- RAM: single-port, synchronous, 16-bit wide, with 1-cycle read latency.
- States:
  - IDLE: `busy` = 0. On `mem_req`=1, latch line index, `mem_wren` and `to_mem`, clear beat, then go to XFER.
  - XFER: issue beats 0..3 on consecutive cycles.
    - Write: RAM write-enable is high for each beat, with the latched word.
    - Read: RAM read for each beat; the returned word is captured into the `from_mem` register slot k one cycle later.
    - After beat 3, go to FIN.
  - FIN: one settle cycle so the last read word is captured. Both read and write pass through FIN, giving a uniform latency. Then go to RDY.
  - RDY: `mem_ready` = 1 for exactly this cycle. Then go to REL.
  - REL: wait until `mem_req` is sampled 0, then go to IDLE. A request still held high after `mem_ready` is never serviced twice.
- Input stability: inputs are sampled only at acceptance. Changes to `mem_address`, `mem_page`, `to_mem` or `mem_wren` during XFER have no effect.
- `from_mem`:
  - Updated only by read beats.
  - Holds its value across writes and idle periods until the next read overwrites it.
  - During a read, slots update progressively; the value is guaranteed only from the `mem_ready` cycle on.
- Reset (`n_reset`=0 at a clock edge):
  - State goes to IDLE; `mem_ready`=0, `busy`=0, `from_mem`=64'h0, beat=0.
  - RAM contents are not cleared. Beats already written during an aborted write remain; the remaining beats are not written.
  - No `mem_ready` is issued for an aborted request.

## Timing
- Cycle T: IDLE with `mem_req`=1, request accepted. `busy` is high from T+1.
- Beat k: RAM access in cycle T+1+k (k = 0..3).
- Read capture: word k is registered at the end of cycle T+2+k.
- `mem_ready`: high during cycle T+6, for both read and write. `from_mem` is valid at T+6 and stays stable afterwards.
- Earliest next acceptance: if `mem_req` is low in T+7, REL samples it and state returns to IDLE at T+8. A new request sampled in IDLE at T+8 is accepted; minimum request period is 8 cycles.
- Simultaneous reset and request: reset wins and the request is not accepted.

## Test plan
- Write then read:
  - Stimulus: write `to_mem`=64'h0123_4567_89AB_CDEF to page 0, address 5, then read the same line.
  - Response: `mem_ready` pulses at T+6 for each request. The read returns 64'h0123_4567_89AB_CDEF. RAM words 20..23 hold CDEF, 89AB, 4567, 0123.
- Held request:
  - Stimulus: keep `mem_req` high for 20 cycles after a read.
  - Response: exactly one `mem_ready` pulse; `busy` stays 1 until `mem_req` drops.
- Back-to-back:
  - Stimulus: read line 3, drop `mem_req` in the cycle after `mem_ready`, immediately request a write to line 4.
  - Response: the second request is accepted 2 cycles after the first `mem_ready` and its `mem_ready` follows 6 cycles later. Line 3 data is unchanged in `from_mem` during the write.
- Aliasing:
  - Stimulus: with LINE_AW=10, write 64'hAAAA… to page 1 / address 0, then read page 0 / address 0x400.
  - Response: the read returns 64'hAAAA…, since both addresses map to line index 0.
- Reset mid-write:
  - Stimulus: line 7 holds all zeros. Pull `n_reset` low in cycle T+3 of a write of 64'hFFFF….
  - Response: no `mem_ready`; `from_mem`=0. A following read of line 7 returns 64'h0000_0000_FFFF_FFFF, because beats 0–1 were written and beats 2–3 were not.

Source files
------------

// File: rtl/line_ram_responder.sv
// line_ram_responder: serves 64-bit cache-line requests from a 16-bit block RAM in four beats
module line_ram_responder #(
    parameter int ADDR_W  = 13,
    parameter int PAGE_W  = 7,
    parameter int LINE_AW = 10
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [PAGE_W-1:0] mem_page,
    input  logic              mem_req,
    input  logic              mem_wren,
    input  logic [63:0]       to_mem,
    output logic [63:0]       from_mem,
    output logic              mem_ready,
    output logic              busy
);
    localparam int DEPTH = 4 << LINE_AW;

    typedef enum logic [2:0] {IDLE, XFER, FIN, RDY, REL} state_t;

    state_t              state_q, state_d;
    logic [LINE_AW-1:0]  line_q, line_d;
    logic                wren_q, wren_d;
    logic [3:0][15:0]    wdata_q, wdata_d;
    logic [1:0]          beat_q, beat_d;
    logic                rd_vld_q;
    logic [1:0]          rd_slot_q;
    logic [15:0]         rdata_q;
    logic [3:0][15:0]    from_mem_q;
    logic                ram_we, ram_re;
    logic [LINE_AW+1:0]  ram_addr;
    logic [15:0]         ram [DEPTH];

    assign ram_addr = {line_q, beat_q};
    assign from_mem = from_mem_q;

    // State and request latches; reset aborts any transfer in flight
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            line_q  <= '0;
            wren_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            wren_q  <= wren_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state, beat sequencing and handshake outputs
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        line_d    = line_q;
        wren_d    = wren_q;
        wdata_d   = wdata_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        busy      = 1'b1;
        mem_ready = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (mem_req) begin
                    line_d  = LINE_AW'({mem_page, mem_address});
                    wren_d  = mem_wren;
                    wdata_d = to_mem;
                    beat_d  = 2'd0;
                    state_d = XFER;
                end
            end
            XFER: begin
                ram_we  = wren_q;
                ram_re  = !wren_q;
                beat_d  = beat_q + 2'd1;
                state_d = (beat_q == 2'd3) ? FIN : XFER;
            end
            FIN: state_d = RDY;
            RDY: begin
                mem_ready = 1'b1;
                state_d   = REL;
            end
            REL: state_d = mem_req ? REL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Block RAM; a write in the reset cycle is suppressed so aborted beats stay unwritten
    always_ff @(posedge clk) begin
        if (ram_we && n_reset) ram[ram_addr] <= wdata_q[beat_q];
        if (ram_re) rdata_q <= ram[ram_addr];
    end

    // Capture each read word into its line slot one cycle after the RAM access
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rd_vld_q   <= 1'b0;
            rd_slot_q  <= 2'd0;
            from_mem_q <= '0;
        end else begin
            rd_vld_q  <= ram_re;
            rd_slot_q <= beat_q;
            if (rd_vld_q) from_mem_q[rd_slot_q] <= rdata_q;
        end
    end
endmodule
